// File: rtl/max7219_chain_ctrl.sv
// Serial driver for a daisy chain of MAX7219 LED-matrix drivers: shifts one
// 16-bit word per device out MSB-first on a divided clock, then strobes LOAD.
module max7219_chain_ctrl #(
    parameter int G_MATRIX_NB = 2,
    parameter int G_CLK_DIV   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_start,
    input  logic [16*G_MATRIX_NB-1:0] i_data,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_max7219_clk,
    output logic                      o_max7219_din,
    output logic                      o_max7219_load
);

    localparam int W     = 16 * G_MATRIX_NB;
    localparam int BIT_W = $clog2(W);
    localparam int DIV_W = $clog2(G_CLK_DIV + 1);

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(W - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(G_CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LOAD
    } state_t;

    state_t           state, state_nxt;
    logic [W-1:0]     sreg, sreg_nxt;
    logic [BIT_W-1:0] bit_cnt, bit_nxt;
    logic [DIV_W-1:0] div_cnt, div_nxt;
    logic             done_nxt;
    logic             phase_end;

    assign phase_end = (div_cnt == DIV_LAST);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_nxt = state;
        sreg_nxt  = sreg;
        bit_nxt   = bit_cnt;
        div_nxt   = div_cnt;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                div_nxt = '0;
                if (i_start) begin
                    sreg_nxt  = i_data;
                    bit_nxt   = BIT_LAST;
                    state_nxt = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (phase_end) begin
                    div_nxt   = '0;
                    state_nxt = SHIFT_HI;
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
            SHIFT_HI: begin
                if (phase_end) begin
                    div_nxt = '0;
                    if (bit_cnt == '0) begin
                        state_nxt = LOAD;
                    end else begin
                        sreg_nxt  = {sreg[W-2:0], 1'b0};
                        bit_nxt   = bit_cnt - BIT_W'(1);
                        state_nxt = SHIFT_LO;
                    end
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
            LOAD: begin
                if (phase_end) begin
                    div_nxt   = '0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pin outputs are registered from the next state so the chain never sees
    // decode glitches; a frame's first bit is therefore valid from E+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            sreg           <= '0;
            bit_cnt        <= '0;
            div_cnt        <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_max7219_clk  <= 1'b0;
            o_max7219_din  <= 1'b0;
            o_max7219_load <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state          <= state_nxt;
            sreg           <= sreg_nxt;
            bit_cnt        <= bit_nxt;
            div_cnt        <= div_nxt;
            o_busy         <= (state_nxt != IDLE);
            o_done         <= done_nxt;
            o_max7219_clk  <= (state_nxt == SHIFT_HI);
            o_max7219_din  <= ((state_nxt == SHIFT_LO) || (state_nxt == SHIFT_HI)) & sreg_nxt[W-1];
            o_max7219_load <= (state_nxt == LOAD);
        end
    end

endmodule

// File: tb/tb_max7219_chain_ctrl.sv
// Self-checking bench: a MAX7219 chain emulator (shift on rising clk, latch on
// LOAD) judges random and directed frames on a 2x/div-4 and a 1x/div-1 instance.
module tb_max7219_chain_ctrl;

    localparam int N  = 2;
    localparam int D  = 4;
    localparam int W  = 16 * N;
    localparam int CN = 1;
    localparam int CD = 1;
    localparam int CW = 16 * CN;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         start, busy, done, sclk, din, ld;
    logic [W-1:0] data;
    logic          c_start, c_busy, c_done, c_sclk, c_din, c_ld;
    logic [CW-1:0] c_data;

    max7219_chain_ctrl #(.G_MATRIX_NB(N), .G_CLK_DIV(D)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_data(data),
        .o_busy(busy), .o_done(done), .o_max7219_clk(sclk),
        .o_max7219_din(din), .o_max7219_load(ld)
    );

    max7219_chain_ctrl #(.G_MATRIX_NB(CN), .G_CLK_DIV(CD)) dut_c (
        .clk(clk), .rst_n(rst_n), .i_start(c_start), .i_data(c_data),
        .o_busy(c_busy), .o_done(c_done), .o_max7219_clk(c_sclk),
        .o_max7219_din(c_din), .o_max7219_load(c_ld)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Chain emulator and frame statistics for the main instance.
    logic [W-1:0] m_chain = '0;
    logic [W-1:0] m_latch_q[$];
    int m_edges, m_busy, m_load, m_pulses, m_done, m_clk_in_load;
    logic m_psclk = 1'b0, m_pld = 1'b0;

    always @(negedge clk) begin
        if (sclk && !m_psclk) begin
            m_chain = {m_chain[W-2:0], din};
            m_edges++;
        end
        if ((sclk != m_psclk) && ld && m_pld) m_clk_in_load++;
        if (ld && !m_pld) begin
            m_latch_q.push_back(m_chain);
            m_pulses++;
        end
        if (ld)   m_load++;
        if (busy) m_busy++;
        if (done) m_done++;
        m_psclk = sclk;
        m_pld   = ld;
    end

    // Same emulator for the single-device instance.
    logic [CW-1:0] c_chain = '0;
    logic [CW-1:0] c_latch = '0;
    int c_edges, c_busy_n, c_pulses, c_done_n;
    logic c_psclk = 1'b0, c_pld = 1'b0;

    always @(negedge clk) begin
        if (c_sclk && !c_psclk) begin
            c_chain = {c_chain[CW-2:0], c_din};
            c_edges++;
        end
        if (c_ld && !c_pld) begin
            c_latch = c_chain;
            c_pulses++;
        end
        if (c_busy) c_busy_n++;
        if (c_done) c_done_n++;
        c_psclk = c_sclk;
        c_pld   = c_ld;
    end

    task automatic clear_mon();
        m_latch_q.delete();
        m_edges = 0; m_busy = 0; m_load = 0; m_pulses = 0; m_done = 0; m_clk_in_load = 0;
        c_edges = 0; c_busy_n = 0; c_pulses = 0; c_done_n = 0;
    endtask

    task automatic start_frame(input logic [W-1:0] d);
        @(posedge clk); #1;
        start = 1'b1;
        data  = d;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int i = 0;
        while (m_done < n && i < 2000) begin
            @(posedge clk);
            i++;
        end
        check("done_timeout", 64'(m_done >= n), 64'd1);
    endtask

    task automatic check_main(input logic [W-1:0] d);
        check("latch_count", 64'(m_latch_q.size()), 64'd1);
        if (m_latch_q.size() > 0) check("latched_frame", 64'(m_latch_q[0]), 64'(d));
        check("clk_edges",    64'(m_edges),         64'(W));
        check("load_pulses",  64'(m_pulses),        64'd1);
        check("load_width",   64'(m_load),          64'(D));
        check("busy_cycles",  64'(m_busy),          64'((2 * W + 1) * D));
        check("done_pulses",  64'(m_done),          64'd1);
        check("clk_in_load",  64'(m_clk_in_load),   64'd0);
    endtask

    task automatic corner_frame(input logic [CW-1:0] d);
        int i = 0;
        clear_mon();
        @(posedge clk); #1;
        c_start = 1'b1;
        c_data  = d;
        @(posedge clk); #1;
        c_start = 1'b0;
        while (c_done_n < 1 && i < 500) begin
            @(posedge clk);
            i++;
        end
        repeat (3) @(posedge clk);
        check("c_latched",   64'(c_latch),  64'(d));
        check("c_edges",     64'(c_edges),  64'(CW));
        check("c_busy",      64'(c_busy_n), 64'((2 * CW + 1) * CD));
        check("c_pulses",    64'(c_pulses), 64'd1);
        check("c_done",      64'(c_done_n), 64'd1);
    endtask

    logic [W-1:0] d1, d2;
    int gap;
    int k;

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        data    = '0;
        c_start = 1'b0;
        c_data  = '0;
        clear_mon();
        #2;
        check("reset_outputs",   64'({busy, done, sclk, din, ld}), 64'd0);
        check("reset_outputs_c", 64'({c_busy, c_done, c_sclk, c_din, c_ld}), 64'd0);
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed single frame; device 0 holds the low word, device 1 the high word.
        clear_mon();
        start_frame(32'h0C01_0F00);
        wait_done(1);
        repeat (5) @(posedge clk);
        check_main(32'h0C01_0F00);
        if (m_latch_q.size() > 0) begin
            check("device0", 64'(m_latch_q[0][15:0]),  64'h0F00);
            check("device1", 64'(m_latch_q[0][31:16]), 64'h0C01);
        end

        // Back-to-back with start held: the next frame begins right after done.
        clear_mon();
        d1 = 32'h0101_0203;
        d2 = 32'h0201_0408;
        @(posedge clk); #1;
        start = 1'b1;
        data  = d1;
        @(posedge clk); #1;
        data  = d2;
        wait_done(1);
        #1;
        check("b2b_restart_busy", 64'(busy), 64'd1);
        start = 1'b0;
        wait_done(2);
        repeat (5) @(posedge clk);
        check("b2b_latch_count", 64'(m_latch_q.size()), 64'd2);
        if (m_latch_q.size() == 2) begin
            check("b2b_frame1", 64'(m_latch_q[0]), 64'(d1));
            check("b2b_frame2", 64'(m_latch_q[1]), 64'(d2));
        end
        check("b2b_edges",  64'(m_edges),       64'(2 * W));
        check("b2b_busy",   64'(m_busy),        64'(2 * (2 * W + 1) * D));
        check("b2b_done",   64'(m_done),        64'd2);
        check("b2b_clk_ld", 64'(m_clk_in_load), 64'd0);

        // A start request and new data mid-frame must be ignored.
        clear_mon();
        d1 = $urandom;
        start_frame(d1);
        repeat (100) @(posedge clk); #1;
        data  = '1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1);
        repeat (20) @(posedge clk);
        check_main(d1);
        check("ignored_idle", 64'(busy), 64'd0);

        // Asynchronous reset at bit 10 aborts the frame with no LOAD or done.
        clear_mon();
        start_frame($urandom);
        k = 0;
        while (m_edges < 10 && k < 1000) begin
            @(posedge clk);
            k++;
        end
        @(posedge clk); #2;
        check("busy_before_rst", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_outputs", 64'({busy, done, sclk, din, ld}), 64'd0);
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_no_load", 64'(m_pulses), 64'd0);
        check("rst_no_done", 64'(m_done),   64'd0);
        clear_mon();
        start_frame(32'h0A05_0A05);
        wait_done(1);
        repeat (5) @(posedge clk);
        check_main(32'h0A05_0A05);

        // Random frames separated by random idle gaps.
        for (int i = 0; i < 6; i++) begin
            clear_mon();
            d1  = $urandom;
            gap = $urandom_range(0, 5);
            repeat (gap) @(posedge clk);
            start_frame(d1);
            wait_done(1);
            repeat (3) @(posedge clk);
            check_main(d1);
        end

        // Single device with the divider at its minimum.
        corner_frame(16'h0B07);
        corner_frame(16'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/max7219_chain_ctrl.md
Name: max7219_chain_ctrl

Overview:
- Synthesizable serial driver for a daisy chain of G_MATRIX_NB MAX7219 LED-matrix drivers. Sits directly upstream of the MAX7219 chain, or of its matrix emulator in simulation.
- Accepts one frame holding one 16-bit word per device, shifts it out MSB-first on a divided serial clock, then pulses LOAD so every device latches its word simultaneously.
- Higher-level display logic (init sequencer, character/scroll engines) issues frames through a start/busy/done handshake.

Parameters:
- G_MATRIX_NB, 2, number of chained devices; minimum 1.
- G_CLK_DIV, 4, clk cycles per half-period of o_max7219_clk; minimum 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assertion, active-low.
- i_start  in  1  frame request; sampled only in IDLE.
- i_data  in  16*G_MATRIX_NB  frame. Word k = i_data[16*k+15:16*k] targets device k; device 0 is nearest the controller.
- o_busy  out  1  frame in progress.
- o_done  out  1  one-cycle pulse at frame completion.
- o_max7219_clk  out  1  serial clock to the chain.
- o_max7219_din  out  1  serial data to device 0.
- o_max7219_load  out  1  latch strobe; idle low.

Behaviour:
- Reset values (asynchronous, immediate): state IDLE; o_busy=0, o_done=0, o_max7219_clk=0, o_max7219_din=0, o_max7219_load=0; shift register, bit counter and divider counter = 0.
- Clock/reset: single clk domain; rst_n asynchronous active-low.
- States and phase lengths: IDLE, SHIFT_LO, SHIFT_HI, LOAD. Every non-IDLE phase lasts exactly G_CLK_DIV clk cycles, timed by the divider counter.
- IDLE, i_start=1 at edge E:
  - i_data is captured into the shift register; bit counter set to 16*G_MATRIX_NB-1.
  - From E+1: state SHIFT_LO, o_busy=1.
- SHIFT_LO: o_max7219_clk=0; o_max7219_din = shift register MSB, set on phase entry and stable for the whole LO and HI phase.
- SHIFT_HI: o_max7219_clk=1; the device samples on the rising edge. At phase end:
  - counter=0 -> LOAD;
  - otherwise shift left by 1, decrement counter, -> SHIFT_LO.
- Shift order: i_data[16*G_MATRIX_NB-1] goes first, i.e. the farthest device's word MSB-first; i_data[0] goes last. Bits 15:12 of each word are transmitted unmodified.
- LOAD: o_max7219_clk=0, o_max7219_din=0, o_max7219_load=1. At phase end: load=0, o_busy=0, o_done=1 for one cycle, state IDLE.
- Timing:
  - o_busy is high for exactly (32*G_MATRIX_NB+1)*G_CLK_DIV cycles.
  - Exactly 16*G_MATRIX_NB rising edges of o_max7219_clk per frame.
  - Exactly one LOAD pulse, and no clk edge while load=1.
- i_start while o_busy=1 is ignored; i_data changes while busy have no effect.
- i_start in the o_done cycle is accepted (state is IDLE), so frames run back-to-back with one idle cycle between LOAD fall and the next frame's first data bit.
- Reset mid-frame: all outputs return to reset values immediately; no LOAD pulse, no o_done; the partial shift is discarded and the next frame starts clean.
- G_CLK_DIV=1: each phase lasts one cycle; the same rules hold.
- Counter widths: divider $clog2(G_CLK_DIV+1); bit counter $clog2(16*G_MATRIX_NB). No wrap beyond these ranges.

Test Plan:
- Single frame (N=2, D=4): i_data=32'h0C01_0F00 pulsed one cycle.
  - Bits on o_max7219_din sampled at each rising o_max7219_clk reconstruct 0x0C010F00 MSB-first.
  - 32 rising edges, one LOAD pulse 4 cycles wide, o_busy high 260 cycles, single o_done pulse.
  - Emulator shows device0=0x0F00, device1=0x0C01.
- Back-to-back: i_start held high, i_data=32'h0101_0203 then 32'h0201_0408.
  - Second frame starts the cycle after o_done; both decode correctly; no stray clk edge between frames.
- Start ignored: i_start pulsed 100 cycles into a frame with i_data changed to 32'hFFFF_FFFF.
  - Current frame unaffected; only one o_done.
- Reset mid-frame: rst_n low at bit 10 of a frame.
  - All outputs 0 the same cycle, even without a clk edge; no LOAD or o_done.
  - Next frame 32'h0A05_0A05 decodes correctly.
- Corner G_CLK_DIV=1, G_MATRIX_NB=1: i_data=16'h0B07.
  - 16 rising edges, o_busy high 33 cycles, emulator device0=0x0B07.
